data_mem_responder: RTL
=======================

# data_mem_responder

Word-addressed data-memory responder serving the CPU's load/store port through a request/acknowledge handshake with a parameterised wait-state count. It sits between the datapath's memory-access stage and the on-chip data store. It replaces the zero-latency combinational data memory so the multi-cycle datapath can be exercised against a slow memory.

## Interface
Parameters:
- DEPTH_WORDS, 128, number of 32-bit words stored.
- LATENCY, 2, wait cycles between acceptance and response; legal range 1..15.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- req_i  in  1  request valid; held by the initiator until ack_o.
- we_i  in  1  1 = store, 0 = load; sampled on acceptance.
- addr_i  in  32  byte address; sampled on acceptance.
- wdata_i  in  32  store data; sampled on acceptance.
- be_i  in  4  byte enables for stores, bit n = byte n, little-endian; ignored for loads.
- busy_o  out  1  high while a transaction is in flight (state != IDLE).
- ack_o  out  1  one-cycle response pulse.
- rdata_o  out  32  load data; valid while ack_o is high, held until the next ack.
- err_o  out  1  error flag qualifying ack_o.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_i=1 latches we/addr/wdata/be, loads the wait counter with LATENCY-1, and moves to WAIT.
  - req_i=0 stays in IDLE.
- WAIT:
  - Counter decrements each cycle.
  - At counter 0, moves to RESP.
  - On that same edge, a valid store commits the enabled bytes to the array.
- RESP:
  - ack_o=1 for exactly one cycle.
  - Loads: rdata_o is registered from the array at the latched word index.
  - Always returns to IDLE.
  - req_i is ignored while in RESP.
- Word index = addr[31:2].
- Error conditions: addr[1:0] != 0, or index >= DEPTH_WORDS.
  - On error, ack_o and err_o are both 1.
  - No write occurs.
  - rdata_o = 0.
- A store with be_i = 0 completes with ack_o=1 and err_o=0 and modifies nothing.
- Handshake rule for the initiator: after sampling ack_o, it must either drop req_i or present a new transaction in the next cycle. A request left high is treated as new.
- Any changes to request inputs while busy_o=1 are ignored.

## Timing
- Reset values: state IDLE, busy_o=0, ack_o=0, err_o=0, rdata_o=0, counter 0.
- Reset also clears every array word to 0.
- Reset asserted mid-transaction:
  - The transaction is abandoned immediately.
  - No write commits, even if asserted during the commit cycle.
  - No ack_o is issued.
- Latency: with the request accepted at the end of cycle 0, ack_o is high in cycle LATENCY+1.
- Throughput: one transaction per LATENCY+2 cycles when the initiator holds req_i high continuously.
- busy_o rises the cycle after acceptance and falls the cycle after RESP.
- Read-after-write: a load issued immediately after a store's ack returns the stored data.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared header/package `mem_resp_pkg`:
  - State encodings: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - Counter width constant CNT_W=4.
  - Error-code constants, reserved for future size-mismatch errors.
- Sub-module `mem_resp_array`:
  - DEPTH_WORDS x 32 register array.
  - Byte-enable synchronous write.
  - Asynchronous clear on rst_i.
  - Combinational read port.
- The top level holds the FSM, counter, request latches and output registers.

## Test plan
- Reset then idle: rst_i pulse, then 10 cycles with req_i=0 -> ack_o, busy_o, err_o and rdata_o all 0; a load of addr 0x0 returns 0x00000000.
- Store then load, LATENCY=2:
  - Store 0xDEADBEEF to 0x10 with be=4'hF -> ack_o in cycle 3 after acceptance, err_o=0.
  - Load 0x10 issued the next cycle -> rdata_o=0xDEADBEEF.
- Byte enables: word 0x20 holds 0x11223344; store 0xAABBCCDD with be=4'b0101 -> a load of 0x20 returns 0x11BB33DD.
- Errors:
  - Load 0x03 -> ack_o=1, err_o=1, rdata_o=0.
  - Store to 0x200 with DEPTH_WORDS=128 -> err_o=1, and a subsequent load of 0x0 still returns its prior value.
- Reset mid-operation: store 0x55 to 0x8, assert rst_i during WAIT -> no ack_o; after reset a load of 0x8 returns 0.
- Back-to-back with req_i held high for three loads, LATENCY=1 -> ack_o pulses are exactly 3 cycles apart, and busy_o drops for one cycle between transactions.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and constants for the data-memory responder.
//   state_e      - responder FSM encoding (IDLE/WAIT/RESP)
//   CNT_W        - wait-state counter width (LATENCY up to 15)
//   ERR_*        - error codes; ERR_SIZE is held for future size-mismatch checks
//   mem_req_t    - request fields captured at acceptance
package mem_resp_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_SIZE  = 2'd3;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_req_t;

  // Misaligned byte address or word index beyond the array.
  function automatic logic addr_err(input logic [31:0] addr, input int depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth));
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// mem_resp_array: DEPTH_WORDS x 32 storage for the data-memory responder.
//   clk_i, rst_i  - clock; async active-high clear of every word
//   we_i          - write strobe (one cycle), bytes selected by be_i
//   waddr_i       - write word index
//   wdata_i       - write data
//   be_i          - byte enables, bit n = byte n
//   raddr_i       - read word index
//   rdata_o       - combinational read data
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [DEPTH_WORDS-1:0][31:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_d[waddr_i][8*b +: 8] = wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mem_q <= '0;
    else       mem_q <= mem_d;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory behind a req/ack handshake
// with LATENCY wait cycles between acceptance and the one-cycle ack.
//   clk_i, rst_i              - clock; async active-high reset (also clears array)
//   req_i, we_i, addr_i,
//   wdata_i, be_i             - request, sampled only when accepted in IDLE
//   busy_o                    - transaction in flight
//   ack_o, err_o, rdata_o     - registered response; err_o qualifies ack_o
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        busy_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  mem_req_t           req_q, req_d;
  logic               busy_q, busy_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;

  logic               txn_err;
  logic               mem_we;
  logic [31:0]        arr_rdata;

  assign txn_err = addr_err(req_q.addr, DEPTH_WORDS);

  mem_resp_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (mem_we),
    .waddr_i (req_q.addr[AW+1:2]),
    .wdata_i (req_q.wdata),
    .be_i    (req_q.be),
    .raddr_i (req_q.addr[AW+1:2]),
    .rdata_o (arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          req_d   = '{we: we_i, addr: addr_i, wdata: wdata_i, be: be_i};
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          // Commit and response capture share the edge into RESP, so the
          // ack cycle already presents final rdata/err.
          state_d = RESP;
          ack_d   = 1'b1;
          err_d   = txn_err;
          mem_we  = req_q.we && !txn_err;
          if (txn_err)        rdata_d = '0;
          else if (!req_q.we) rdata_d = arr_rdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy_o  = busy_q;
  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;

endmodule
